// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped, write-through, no-write-allocate, one-word-per-line
// cache controller between a processor port and a shared memory bus requester.
// Read hits are answered locally; read misses and all writes go to the bus and
// are held there until a rising edge of mem_en marks completion.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   cpu_rw/addr/wdata     processor request (held until cpu_ready)
//   cpu_rdata, cpu_ready  read data and one-cycle completion pulse
//   mem_rw/addr/wdata     bus request (non-IDLE = pending)
//   mem_rdata, mem_en     bus read data and completion flag
//   hit_cnt, miss_cnt     saturating request statistics (CACHE_STATS_EN only)
//
// Optional feature macro: CACHE_STATS_EN adds the hit/miss counters.
module cache_ctrl #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned WORD_W  = 8,
   parameter int unsigned INDEX_W = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        cpu_rw,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [WORD_W-1:0] cpu_wdata,
   output logic [WORD_W-1:0] cpu_rdata,
   output logic              cpu_ready,
   output logic [1:0]        mem_rw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   input  logic [WORD_W-1:0] mem_rdata,
   input  logic              mem_en
`ifdef CACHE_STATS_EN
   ,
   output logic [15:0]       hit_cnt,
   output logic [15:0]       miss_cnt
`endif
);

   localparam int unsigned LINES = 1 << INDEX_W;
   localparam int unsigned TAG_W = ADDR_W - INDEX_W;

   localparam logic [1:0] RW_IDLE = 2'd0;
   localparam logic [1:0] RW_RD   = 2'd1;
   localparam logic [1:0] RW_WT   = 2'd2;

   typedef enum logic [1:0] {S_IDLE, S_RD_MISS, S_WR, S_DONE} state_e;

   state_e            state_q, state_d;
   logic              cpu_ready_q, cpu_ready_d;
   logic [WORD_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [1:0]        mem_rw_q, mem_rw_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              mem_en_q, mem_en_d;

   logic [LINES-1:0]  valid_q, valid_d;
   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [TAG_W-1:0]  tag_d  [LINES];
   logic [WORD_W-1:0] data_q [LINES];
   logic [WORD_W-1:0] data_d [LINES];

   logic [INDEX_W-1:0] cpu_idx, fill_idx;
   logic [TAG_W-1:0]   cpu_tag, fill_tag;
   logic               hit;
   logic               mem_done;

   assign cpu_idx  = cpu_addr[INDEX_W-1:0];
   assign cpu_tag  = cpu_addr[ADDR_W-1:INDEX_W];
   // Fill uses the latched bus address, which is stable for the whole miss.
   assign fill_idx = mem_addr_q[INDEX_W-1:0];
   assign fill_tag = mem_addr_q[ADDR_W-1:INDEX_W];
   assign hit      = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
   // Only a rising edge completes, so a level left high by the previous
   // transfer cannot finish the next one early.
   assign mem_done = mem_en && !mem_en_q;

   // Next-state, bus request and array update logic.
   always_comb begin
      state_d     = state_q;
      cpu_ready_d = 1'b0;
      cpu_rdata_d = cpu_rdata_q;
      mem_rw_d    = mem_rw_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_en_d    = mem_en;
      valid_d     = valid_q;
      tag_d       = tag_q;
      data_d      = data_q;

      case (state_q)
         S_IDLE: begin
            if (cpu_rw == RW_RD) begin
               if (hit) begin
                  cpu_rdata_d = data_q[cpu_idx];
                  cpu_ready_d = 1'b1;
                  state_d     = S_DONE;
               end else begin
                  mem_rw_d   = RW_RD;
                  mem_addr_d = cpu_addr;
                  state_d    = S_RD_MISS;
               end
            end else if (cpu_rw == RW_WT) begin
               mem_rw_d    = RW_WT;
               mem_addr_d  = cpu_addr;
               mem_wdata_d = cpu_wdata;
               if (hit) begin
                  data_d[cpu_idx] = cpu_wdata;
               end
               state_d = S_WR;
            end
         end
         S_RD_MISS: begin
            if (mem_done) begin
               valid_d[fill_idx] = 1'b1;
               tag_d[fill_idx]   = fill_tag;
               data_d[fill_idx]  = mem_rdata;
               cpu_rdata_d       = mem_rdata;
               cpu_ready_d       = 1'b1;
               mem_rw_d          = RW_IDLE;
               state_d           = S_DONE;
            end
         end
         S_WR: begin
            if (mem_done) begin
               cpu_ready_d = 1'b1;
               mem_rw_d    = RW_IDLE;
               state_d     = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Control and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cpu_ready_q <= 1'b0;
         cpu_rdata_q <= '0;
         mem_rw_q    <= RW_IDLE;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_en_q    <= 1'b0;
         valid_q     <= '0;
      end else begin
         state_q     <= state_d;
         cpu_ready_q <= cpu_ready_d;
         cpu_rdata_q <= cpu_rdata_d;
         mem_rw_q    <= mem_rw_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_en_q    <= mem_en_d;
         valid_q     <= valid_d;
      end
   end

   // Tag and data storage; contents are qualified by valid_q, so no reset.
   always_ff @(posedge clk) begin
      tag_q  <= tag_d;
      data_q <= data_d;
   end

   assign cpu_ready = cpu_ready_q;
   assign cpu_rdata = cpu_rdata_q;
   assign mem_rw    = mem_rw_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

`ifdef CACHE_STATS_EN
   logic [15:0] hit_cnt_q, hit_cnt_d;
   logic [15:0] miss_cnt_q, miss_cnt_d;

   // One count per processor request accepted in S_IDLE; both saturate.
   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if ((state_q == S_IDLE) && ((cpu_rw == RW_RD) || (cpu_rw == RW_WT))) begin
         if (hit) begin
            if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
         end else begin
            if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed testbench for cache_ctrl with a simple bus responder: each request
// is answered bus_delay cycles after it first appears, with mem_en held high
// for bus_pulse cycles and mem_rdata valid only in the first of them.
module tb_cache_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] cpu_rw;
   logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic       cpu_ready;
   logic [1:0] mem_rw;
   logic [7:0] mem_addr, mem_wdata, mem_rdata;
   logic       mem_en;
`ifdef CACHE_STATS_EN
   logic [15:0] hit_cnt, miss_cnt;
`endif

   int pass_cnt  = 0;
   int total_cnt = 0;
   int bus_delay = 6;
   int bus_pulse = 2;
   logic [7:0] bus_mem [256];

   always #5 clk = ~clk;

   cache_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_rw    (cpu_rw),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_ready (cpu_ready),
      .mem_rw    (mem_rw),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_en    (mem_en)
`ifdef CACHE_STATS_EN
      ,
      .hit_cnt   (hit_cnt),
      .miss_cnt  (miss_cnt)
`endif
   );

   // Bus responder.
   initial begin : bus_model
      logic [7:0] a;
      logic [7:0] w;
      logic [1:0] rw;
      mem_en    = 1'b0;
      mem_rdata = 8'hEE;
      forever begin
         @(posedge clk); #1;
         if (mem_rw != 2'd0) begin
            a = mem_addr; w = mem_wdata; rw = mem_rw;
            repeat (bus_delay) begin @(posedge clk); #1; end
            mem_en    = 1'b1;
            mem_rdata = bus_mem[a];
            if (rw == 2'd2) bus_mem[a] = w;
            @(posedge clk); #1;
            mem_rdata = 8'hEE;
            repeat (bus_pulse - 1) begin @(posedge clk); #1; end
            mem_en = 1'b0;
         end
      end
   end

   // Issue one request (caller is 1 time unit after a posedge = cycle 0) and
   // observe it until cpu_ready or a 60-cycle budget runs out (rdy = -1).
   task automatic run_req(input logic [1:0] rw, input logic [7:0] addr,
                          input logic [7:0] wd, output int rdy, output int rise,
                          output logic [7:0] rd, output logic [1:0] rw1,
                          output logic [7:0] a1, output logic [7:0] w1,
                          output logic [1:0] rw_rdy, output bit stable,
                          output bit bus_seen);
      logic prev_en;
      cpu_rw = rw; cpu_addr = addr; cpu_wdata = wd;
      rdy = -1; rise = -1; rd = '0; rw1 = '0; a1 = '0; w1 = '0; rw_rdy = '0;
      stable = 1'b1; bus_seen = 1'b0; prev_en = mem_en;
      for (int c = 1; c <= 60 && rdy < 0; c++) begin
         @(posedge clk); @(negedge clk);
         if (c == 1) begin rw1 = mem_rw; a1 = mem_addr; w1 = mem_wdata; end
         if (mem_rw != 2'd0) begin
            bus_seen = 1'b1;
            if (mem_rw !== rw1 || mem_addr !== a1 || mem_wdata !== w1) stable = 1'b0;
         end
         if (mem_en && !prev_en && rise < 0) rise = c;
         prev_en = mem_en;
         if (cpu_ready) begin rdy = c; rd = cpu_rdata; rw_rdy = mem_rw; end
      end
      @(posedge clk); #1;
      cpu_rw = 2'd0;
   endtask

   int rdy, rise;
   logic [7:0] rd, a1, w1;
   logic [1:0] rw1, rw_rdy;
   bit stable, bus_seen;

   task automatic test_reset();
      reset = 1'b1; cpu_rw = 2'd0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      total_cnt++; if (cpu_ready !== 1'b0) $display("FAIL reset_ready: got %0b want 0", cpu_ready); else pass_cnt++;
      total_cnt++; if (cpu_rdata !== 8'h00) $display("FAIL reset_rdata: got %h want 00", cpu_rdata); else pass_cnt++;
      total_cnt++; if (mem_rw !== 2'd0) $display("FAIL reset_mem_rw: got %0d want 0", mem_rw); else pass_cnt++;
      total_cnt++; if (mem_addr !== 8'h00) $display("FAIL reset_mem_addr: got %h want 00", mem_addr); else pass_cnt++;
      total_cnt++; if (mem_wdata !== 8'h00) $display("FAIL reset_mem_wdata: got %h want 00", mem_wdata); else pass_cnt++;
`ifdef CACHE_STATS_EN
      total_cnt++; if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) $display("FAIL reset_counters: got %0d/%0d want 0/0", hit_cnt, miss_cnt); else pass_cnt++;
`endif
      @(posedge clk); #1;
   endtask

   // Miss: bus sees it at cycle 1, mem_en rises at 1+6=7, cpu_ready at 8.
   task automatic test_read_miss_hit();
      run_req(2'd1, 8'h05, 8'h00, rdy, rise, rd, rw1, a1, w1, rw_rdy, stable, bus_seen);
      total_cnt++; if (rw1 !== 2'd1 || a1 !== 8'h05) $display("FAIL rdmiss_bus_req: got rw=%0d addr=%h want 1/05", rw1, a1); else pass_cnt++;
      total_cnt++; if (rdy !== 8 || rise !== 7) $display("FAIL rdmiss_latency: got ready=%0d rise=%0d want 8/7", rdy, rise); else pass_cnt++;
      total_cnt++; if (rd !== 8'h3C) $display("FAIL rdmiss_data: got %h want 3c", rd); else pass_cnt++;
      total_cnt++; if (rw_rdy !== 2'd0) $display("FAIL rdmiss_rw_idle: got %0d want 0", rw_rdy); else pass_cnt++;
      run_req(2'd1, 8'h05, 8'h00, rdy, rise, rd, rw1, a1, w1, rw_rdy, stable, bus_seen);
      total_cnt++; if (rdy !== 1 || bus_seen !== 1'b0) $display("FAIL rdhit_latency: got ready=%0d bus=%0b want 1/0", rdy, bus_seen); else pass_cnt++;
      total_cnt++; if (rd !== 8'h3C) $display("FAIL rdhit_data: got %h want 3c", rd); else pass_cnt++;
   endtask

   task automatic test_write_hit();
      run_req(2'd2, 8'h05, 8'hA7, rdy, rise, rd, rw1, a1, w1, rw_rdy, stable, bus_seen);
      total_cnt++; if (rw1 !== 2'd2 || a1 !== 8'h05 || w1 !== 8'hA7) $display("FAIL wrhit_bus_req: got rw=%0d addr=%h wd=%h want 2/05/a7", rw1, a1, w1); else pass_cnt++;
      total_cnt++; if (stable !== 1'b1) $display("FAIL wrhit_bus_stable: got %0b want 1", stable); else pass_cnt++;
      total_cnt++; if (rdy !== 8 || rw_rdy !== 2'd0) $display("FAIL wrhit_done: got ready=%0d rw=%0d want 8/0", rdy, rw_rdy); else pass_cnt++;
      run_req(2'd1, 8'h05, 8'h00, rdy, rise, rd, rw1, a1, w1, rw_rdy, stable, bus_seen);
      total_cnt++; if (rdy !== 1 || rd !== 8'hA7) $display("FAIL wrhit_readback: got ready=%0d data=%h want 1/a7", rdy, rd); else pass_cnt++;
   endtask

   task automatic test_write_miss();
      run_req(2'd2, 8'h11, 8'h22, rdy, rise, rd, rw1, a1, w1, rw_rdy, stable, bus_seen);
      total_cnt++; if (rw1 !== 2'd2 || w1 !== 8'h22 || rdy !== 8) $display("FAIL wrmiss_bus: got rw=%0d wd=%h ready=%0d want 2/22/8", rw1, w1, rdy); else pass_cnt++;
      run_req(2'd1, 8'h11, 8'h00, rdy, rise, rd, rw1, a1, w1, rw_rdy, stable, bus_seen);
      total_cnt++; if (rw1 !== 2'd1 || a1 !== 8'h11) $display("FAIL wrmiss_no_alloc: got rw=%0d addr=%h want 1/11", rw1, a1); else pass_cnt++;
      total_cnt++; if (rd !== 8'h22 || rdy !== 8) $display("FAIL wrmiss_fetch: got data=%h ready=%0d want 22/8", rd, rdy); else pass_cnt++;
   endtask

   // 8'h01 and 8'h05 share index 1 and evict each other.
   task automatic test_conflict();
      logic [7:0] addrs [3];
      logic [7:0] exp   [3];
      addrs[0] = 8'h01; addrs[1] = 8'h05; addrs[2] = 8'h01;
      exp[0]   = 8'h5A; exp[1]   = 8'hA7; exp[2]   = 8'h5A;
      for (int i = 0; i < 3; i++) begin
         run_req(2'd1, addrs[i], 8'h00, rdy, rise, rd, rw1, a1, w1, rw_rdy, stable, bus_seen);
         total_cnt++; if (rw1 !== 2'd1 || rd !== exp[i]) $display("FAIL conflict_%0d: got rw=%0d data=%h want 1/%h", i, rw1, rd, exp[i]); else pass_cnt++;
      end
`ifdef CACHE_STATS_EN
      // Hits: RD05, WT05, RD05. Misses: RD05, WT11, RD11, RD01, RD05, RD01.
      total_cnt++; if (hit_cnt !== 16'd3 || miss_cnt !== 16'd6) $display("FAIL stats: got %0d/%0d want 3/6", hit_cnt, miss_cnt); else pass_cnt++;
`endif
   endtask

   // With a 5-cycle mem_en the second miss reaches the bus while mem_en is
   // still high; it must wait for the next rise (k+12 -> relative cycle 10).
   task automatic test_back_to_back();
      bus_pulse = 5;
      run_req(2'd1, 8'h22, 8'h00, rdy, rise, rd, rw1, a1, w1, rw_rdy, stable, bus_seen);
      total_cnt++; if (rdy !== 8 || rd !== 8'h77) $display("FAIL b2b_first: got ready=%0d data=%h want 8/77", rdy, rd); else pass_cnt++;
      run_req(2'd1, 8'h33, 8'h00, rdy, rise, rd, rw1, a1, w1, rw_rdy, stable, bus_seen);
      total_cnt++; if (rise !== 10 || rdy !== 11) $display("FAIL b2b_no_early_done: got rise=%0d ready=%0d want 10/11", rise, rdy); else pass_cnt++;
      total_cnt++; if (rd !== 8'h99) $display("FAIL b2b_data: got %h want 99", rd); else pass_cnt++;
      bus_pulse = 2;
      repeat (8) @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid();
      int bad;
      bad = 0;
      cpu_rw = 2'd1; cpu_addr = 8'h26; cpu_wdata = 8'h00;
      @(posedge clk); @(negedge clk);
      total_cnt++; if (mem_rw !== 2'd1 || mem_addr !== 8'h26) $display("FAIL rstmid_pending: got rw=%0d addr=%h want 1/26", mem_rw, mem_addr); else pass_cnt++;
      @(posedge clk); #1;
      reset = 1'b1; cpu_rw = 2'd0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      total_cnt++; if (mem_rw !== 2'd0 || cpu_ready !== 1'b0) $display("FAIL rstmid_abandon: got rw=%0d ready=%0b want 0/0", mem_rw, cpu_ready); else pass_cnt++;
      // The responder still raises mem_en for the abandoned request here.
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (cpu_ready !== 1'b0 || mem_rw !== 2'd0) bad++;
      end
      total_cnt++; if (bad !== 0) $display("FAIL rstmid_trailing_pulse: got %0d bad cycles want 0", bad); else pass_cnt++;
      @(posedge clk); #1;
      run_req(2'd1, 8'h26, 8'h00, rdy, rise, rd, rw1, a1, w1, rw_rdy, stable, bus_seen);
      total_cnt++; if (rw1 !== 2'd1 || rdy !== 8 || rd !== 8'h44) $display("FAIL rstmid_recover: got rw=%0d ready=%0d data=%h want 1/8/44", rw1, rdy, rd); else pass_cnt++;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) bus_mem[i] = 8'h00;
      bus_mem[8'h05] = 8'h3C;
      bus_mem[8'h01] = 8'h5A;
      bus_mem[8'h22] = 8'h77;
      bus_mem[8'h33] = 8'h99;
      bus_mem[8'h26] = 8'h44;
      test_reset();
      test_read_miss_hit();
      test_write_hit();
      test_write_miss();
      test_conflict();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
